// File: rtl/audio_mixer.sv
// -----------------------------------------------------------------------------
// audio_mixer
//
// Four-channel audio mixer feeding the codec I2S output stage. On each rising
// edge of the codec sample strobe, all four channels, their gains and the
// mute request are snapshotted. The four products are then accumulated on a
// single time-shared multiplier (A, C into left; B, D into right). The sums
// are scaled back by the unity gain, saturated to SAMPLE_W bits and
// registered onto left_o/right_o together with a one-cycle valid pulse.
//
// Ports:
//   clk_i         system clock (same domain as the sample strobe)
//   rst_i         synchronous, active-high reset
//   sample_clk_i  codec sample strobe; a rising edge requests one mixed sample
//   channel_*_i   signed channel samples (A, C -> left; B, D -> right)
//   gain_*_i      unsigned per-channel gains, unity = 2^(GAIN_W-1)
//   mute_i        forces the sample produced from this edge to zero
//   left_o        mixed left sample, held between updates
//   right_o       mixed right sample, held between updates
//   valid_o       one-cycle pulse when left_o/right_o update
//   clip_o        one-cycle pulse with valid_o when either side saturated
//   overrun_o     one-cycle pulse when a strobe edge arrives while busy
//   busy_o        high while a mix is in progress
// -----------------------------------------------------------------------------
module audio_mixer #(
  parameter int GAIN_W   = 8,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sample_clk_i,
  input  logic signed [SAMPLE_W-1:0] channel_a_i,
  input  logic signed [SAMPLE_W-1:0] channel_b_i,
  input  logic signed [SAMPLE_W-1:0] channel_c_i,
  input  logic signed [SAMPLE_W-1:0] channel_d_i,
  input  logic        [GAIN_W-1:0]   gain_a_i,
  input  logic        [GAIN_W-1:0]   gain_b_i,
  input  logic        [GAIN_W-1:0]   gain_c_i,
  input  logic        [GAIN_W-1:0]   gain_d_i,
  input  logic                       mute_i,
  output logic signed [SAMPLE_W-1:0] left_o,
  output logic signed [SAMPLE_W-1:0] right_o,
  output logic                       valid_o,
  output logic                       clip_o,
  output logic                       overrun_o,
  output logic                       busy_o
);

  // Product of a signed sample and a zero-extended gain, and the accumulator
  // that holds the sum of two such products without overflow.
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + 1;
  localparam int SHIFT  = GAIN_W - 1;

  // Saturation limits expressed at accumulator width so the shifted sum can
  // be compared directly.
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC_A = 3'd1,
    ST_MAC_C = 3'd2,
    ST_MAC_B = 3'd3,
    ST_MAC_D = 3'd4,
    ST_SAT   = 3'd5
  } state_e;

  // Scale an accumulated sum back by the unity gain (floor toward -inf via
  // arithmetic shift) and clamp it. Returns {clipped, value}.
  function automatic logic [SAMPLE_W:0] sat_fn(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shr;
    shr = acc >>> SHIFT;
    if (shr > OUT_MAX) begin
      sat_fn = {1'b1, OUT_MAX[SAMPLE_W-1:0]};
    end else if (shr < OUT_MIN) begin
      sat_fn = {1'b1, OUT_MIN[SAMPLE_W-1:0]};
    end else begin
      sat_fn = {1'b0, shr[SAMPLE_W-1:0]};
    end
  endfunction

  // Registered state
  state_e                     state_q,   state_d;
  logic                       prev_q,    prev_d;
  logic signed [SAMPLE_W-1:0] ch_a_q,    ch_a_d;
  logic signed [SAMPLE_W-1:0] ch_b_q,    ch_b_d;
  logic signed [SAMPLE_W-1:0] ch_c_q,    ch_c_d;
  logic signed [SAMPLE_W-1:0] ch_d_q,    ch_d_d;
  logic        [GAIN_W-1:0]   gain_a_q,  gain_a_d;
  logic        [GAIN_W-1:0]   gain_b_q,  gain_b_d;
  logic        [GAIN_W-1:0]   gain_c_q,  gain_c_d;
  logic        [GAIN_W-1:0]   gain_d_q,  gain_d_d;
  logic                       mute_q,    mute_d;
  logic signed [ACC_W-1:0]    acc_l_q,   acc_l_d;
  logic signed [ACC_W-1:0]    acc_r_q,   acc_r_d;
  logic signed [SAMPLE_W-1:0] left_q,    left_d;
  logic signed [SAMPLE_W-1:0] right_q,   right_d;
  logic                       valid_q,   valid_d;
  logic                       clip_q,    clip_d;
  logic                       busy_q,    busy_d;

  // Datapath nets
  logic                       rise_s;
  logic signed [SAMPLE_W-1:0] op_ch_s;
  logic        [GAIN_W-1:0]   op_gain_s;
  logic signed [PROD_W-1:0]   op_ch_ext_s;
  logic signed [PROD_W-1:0]   op_gain_ext_s;
  logic signed [PROD_W-1:0]   prod_s;
  logic signed [ACC_W-1:0]    prod_ext_s;
  logic        [SAMPLE_W:0]   sat_l_s;
  logic        [SAMPLE_W:0]   sat_r_s;

  assign rise_s = sample_clk_i & ~prev_q;

  // Multiplier operand select: the state names which snapshot channel is in
  // the multiplier this cycle.
  always_comb begin
    op_ch_s   = '0;
    op_gain_s = '0;
    case (state_q)
      ST_MAC_A: begin
        op_ch_s   = ch_a_q;
        op_gain_s = gain_a_q;
      end
      ST_MAC_C: begin
        op_ch_s   = ch_c_q;
        op_gain_s = gain_c_q;
      end
      ST_MAC_B: begin
        op_ch_s   = ch_b_q;
        op_gain_s = gain_b_q;
      end
      ST_MAC_D: begin
        op_ch_s   = ch_d_q;
        op_gain_s = gain_d_q;
      end
      default: begin
        op_ch_s   = '0;
        op_gain_s = '0;
      end
    endcase
  end

  // Both operands are widened to the full product width so the signed
  // multiply is exact; the gain is zero-extended so 255 stays positive.
  assign op_ch_ext_s   = {{(PROD_W-SAMPLE_W){op_ch_s[SAMPLE_W-1]}}, op_ch_s};
  assign op_gain_ext_s = {{(PROD_W-GAIN_W){1'b0}}, op_gain_s};
  assign prod_s        = op_ch_ext_s * op_gain_ext_s;
  assign prod_ext_s    = {prod_s[PROD_W-1], prod_s};

  assign sat_l_s = sat_fn(acc_l_q);
  assign sat_r_s = sat_fn(acc_r_q);

  // Next-state logic for the sequencer, snapshot, accumulators and outputs.
  always_comb begin
    state_d  = state_q;
    prev_d   = sample_clk_i;
    ch_a_d   = ch_a_q;
    ch_b_d   = ch_b_q;
    ch_c_d   = ch_c_q;
    ch_d_d   = ch_d_q;
    gain_a_d = gain_a_q;
    gain_b_d = gain_b_q;
    gain_c_d = gain_c_q;
    gain_d_d = gain_d_q;
    mute_d   = mute_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = 1'b0;
    clip_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          ch_a_d   = channel_a_i;
          ch_b_d   = channel_b_i;
          ch_c_d   = channel_c_i;
          ch_d_d   = channel_d_i;
          gain_a_d = gain_a_i;
          gain_b_d = gain_b_i;
          gain_c_d = gain_c_i;
          gain_d_d = gain_d_i;
          mute_d   = mute_i;
          acc_l_d  = '0;
          acc_r_d  = '0;
          state_d  = ST_MAC_A;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_MAC_A: begin
        acc_l_d = acc_l_q + prod_ext_s;
        state_d = ST_MAC_C;
      end
      ST_MAC_C: begin
        acc_l_d = acc_l_q + prod_ext_s;
        state_d = ST_MAC_B;
      end
      ST_MAC_B: begin
        acc_r_d = acc_r_q + prod_ext_s;
        state_d = ST_MAC_D;
      end
      ST_MAC_D: begin
        acc_r_d = acc_r_q + prod_ext_s;
        state_d = ST_SAT;
      end
      ST_SAT: begin
        // Mute wins over saturation: output is silence and no clip is flagged.
        if (mute_q) begin
          left_d  = '0;
          right_d = '0;
          clip_d  = 1'b0;
        end else begin
          left_d  = sat_l_s[SAMPLE_W-1:0];
          right_d = sat_r_s[SAMPLE_W-1:0];
          clip_d  = sat_l_s[SAMPLE_W] | sat_r_s[SAMPLE_W];
        end
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State register with synchronous reset. The strobe history resets high so
  // a strobe already high when reset releases is not taken as an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      prev_q   <= 1'b1;
      ch_a_q   <= '0;
      ch_b_q   <= '0;
      ch_c_q   <= '0;
      ch_d_q   <= '0;
      gain_a_q <= '0;
      gain_b_q <= '0;
      gain_c_q <= '0;
      gain_d_q <= '0;
      mute_q   <= 1'b0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
      clip_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      ch_a_q   <= ch_a_d;
      ch_b_q   <= ch_b_d;
      ch_c_q   <= ch_c_d;
      ch_d_q   <= ch_d_d;
      gain_a_q <= gain_a_d;
      gain_b_q <= gain_b_d;
      gain_c_q <= gain_c_d;
      gain_d_q <= gain_d_d;
      mute_q   <= mute_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      left_q   <= left_d;
      right_q  <= right_d;
      valid_q  <= valid_d;
      clip_q   <= clip_d;
      busy_q   <= busy_d;
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;
  assign clip_o  = clip_q;
  assign busy_o  = busy_q;
  // The dropped edge must be flagged in the very cycle it appears, so this
  // is a decode of the live edge against the registered busy flag.
  assign overrun_o = rise_s & busy_q;

endmodule

// File: tb/tb_audio_mixer.sv
// -----------------------------------------------------------------------------
// tb_audio_mixer
//
// Self-checking bench for audio_mixer: directed scenarios followed by random
// mixes, compared against an arithmetic reference model of the mixing rules.
// -----------------------------------------------------------------------------
module tb_audio_mixer;

  localparam int GAIN_W   = 8;
  localparam int SAMPLE_W = 16;
  localparam longint UNITY = 128;

  logic clk = 1'b0;
  logic rst;
  logic sample_clk;
  logic signed [SAMPLE_W-1:0] ch_a, ch_b, ch_c, ch_d;
  logic [GAIN_W-1:0] g_a, g_b, g_c, g_d;
  logic mute;
  logic signed [SAMPLE_W-1:0] left, right;
  logic valid, clip, overrun, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  audio_mixer #(.GAIN_W(GAIN_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk_i(clk), .rst_i(rst), .sample_clk_i(sample_clk),
    .channel_a_i(ch_a), .channel_b_i(ch_b), .channel_c_i(ch_c), .channel_d_i(ch_d),
    .gain_a_i(g_a), .gain_b_i(g_b), .gain_c_i(g_c), .gain_d_i(g_d),
    .mute_i(mute), .left_o(left), .right_o(right), .valid_o(valid),
    .clip_o(clip), .overrun_o(overrun), .busy_o(busy)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One side of the mix: floor((x*gx + y*gy) / unity), clamped to 16 bits.
  function automatic void model(input int x, input int y, input int gx, input int gy,
                                input bit m, output int o, output bit c);
    longint s, q;
    s = longint'(x) * gx + longint'(y) * gy;
    q = s / UNITY;
    if (s < 0 && (s % UNITY) != 0) q = q - 1;
    c = 1'b0;
    if (q > 32767) begin
      o = 32767; c = 1'b1;
    end else if (q < -32768) begin
      o = -32768; c = 1'b1;
    end else begin
      o = int'(q);
    end
    if (m) begin
      o = 0; c = 1'b0;
    end
  endfunction

  task automatic drive(input logic signed [15:0] a, b, c, d,
                       input logic [7:0] ga, gb, gc, gd, input bit m);
    ch_a = a; ch_b = b; ch_c = c; ch_d = d;
    g_a = ga; g_b = gb; g_c = gc; g_d = gd;
    mute = m;
  endtask

  // Full transaction: edge in cycle N, busy N+1..N+5, valid only at N+6.
  // With perturb set, inputs are scrambled at N+2 to prove the snapshot.
  task automatic mix(input string tag, input logic signed [15:0] a, b, c, d,
                     input logic [7:0] ga, gb, gc, gd, input bit m, input bit perturb,
                     output int el, output int er);
    bit cl, cr;
    drive(a, b, c, d, ga, gb, gc, gd, m);
    model(int'(a), int'(c), int'(ga), int'(gc), m, el, cl);
    model(int'(b), int'(d), int'(gb), int'(gd), m, er, cr);
    sample_clk = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) sample_clk = 1'b0;
      if (perturb && k == 2) begin
        ch_a = ~a; ch_b = ~b; g_a = ~ga; g_b = ~gb; mute = ~m;
      end
      check({tag, "/valid"}, 32'(valid), 32'(k == 6));
      check({tag, "/busy"}, 32'(busy), 32'(k < 6));
    end
    check({tag, "/left"}, 32'(left), el);
    check({tag, "/right"}, 32'(right), er);
    check({tag, "/clip"}, 32'(clip), 32'(cl | cr));
  endtask

  // Outputs must hold, and valid stay low, while inputs wander and no edge comes.
  task automatic hold(input string tag, input int el, input int er);
    for (int k = 0; k < 3; k++) begin
      drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      tick();
      check({tag, "/hold_valid"}, 32'(valid), 32'd0);
      check({tag, "/hold_left"}, 32'(left), el);
      check({tag, "/hold_right"}, 32'(right), er);
    end
  endtask

  initial begin
    int el, er, el2, er2, nvalid;
    bit cl, cr;

    rst = 1'b1;
    sample_clk = 1'b0;
    drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick();
    tick();
    check("reset/left", 32'(left), 32'd0);
    check("reset/right", 32'(right), 32'd0);
    check("reset/valid", 32'(valid), 32'd0);
    check("reset/clip", 32'(clip), 32'd0);
    check("reset/overrun", 32'(overrun), 32'd0);
    check("reset/busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Unity mix
    mix("unity", 16'sd1000, -16'sd500, 16'sd2000, -16'sd700,
        8'd128, 8'd128, 8'd128, 8'd128, 1'b0, 1'b0, el, er);
    check("unity/left_abs", 32'(left), 32'sd3000);
    check("unity/right_abs", 32'(right), -32'sd1200);

    // Saturation on each side, then hold
    mix("sat_l", 16'sd32767, 16'sd10, 16'sd32767, 16'sd20,
        8'd255, 8'd128, 8'd255, 8'd128, 1'b0, 1'b0, el, er);
    hold("sat_l", el, er);
    mix("sat_r", 16'sd0, -16'sd32768, 16'sd0, -16'sd32768,
        8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 1'b0, el, er);
    hold("sat_r", el, er);

    // Rounding toward -inf and zero gain
    mix("round_pos", 16'sd1001, 16'sd0, 16'sd0, 16'sd0,
        8'd64, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, el, er);
    check("round_pos/abs", 32'(left), 32'sd500);
    mix("round_neg", -16'sd1001, 16'sd0, 16'sd0, 16'sd0,
        8'd64, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, el, er);
    check("round_neg/abs", 32'(left), -32'sd501);
    mix("gain0", -16'sd32768, 16'sd12345, 16'sd32767, -16'sd3,
        8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, el, er);

    // Mute and snapshot
    mix("mute", 16'sd30000, 16'sd30000, 16'sd30000, 16'sd30000,
        8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 1'b0, el, er);
    mix("snap", 16'sd4000, -16'sd1234, 16'sd100, 16'sd77,
        8'd200, 8'd90, 8'd128, 8'd1, 1'b0, 1'b1, el, er);

    // Overrun: second edge at N+3 dropped; edge at N+6 accepted
    drive(16'sd100, 16'sd200, 16'sd300, 16'sd400, 8'd128, 8'd128, 8'd128, 8'd128, 1'b0);
    model(100, 300, 128, 128, 1'b0, el, cl);
    model(200, 400, 128, 128, 1'b0, er, cr);
    model(-50, 60, 255, 3, 1'b0, el2, cl);
    model(70, -80, 128, 128, 1'b0, er2, cr);
    sample_clk = 1'b1;
    nvalid = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1 || k == 4) sample_clk = 1'b0;
      if (k == 3) sample_clk = 1'b1;
      if (k == 6) begin
        drive(-16'sd50, 16'sd70, 16'sd60, -16'sd80, 8'd255, 8'd128, 8'd3, 8'd128, 1'b0);
        sample_clk = 1'b1;
      end
      #1;
      check("ovr/overrun", 32'(overrun), 32'(k == 3));
      if (valid) nvalid++;
    end
    check("ovr/nvalid", nvalid, 32'd1);
    check("ovr/valid6", 32'(valid), 32'd1);
    check("ovr/left", 32'(left), el);
    check("ovr/right", 32'(right), er);
    for (int k = 7; k <= 12; k++) begin
      tick();
      if (k == 7) sample_clk = 1'b0;
      check("ovr/valid2", 32'(valid), 32'(k == 12));
    end
    check("ovr/left2", 32'(left), el2);
    check("ovr/right2", 32'(right), er2);

    // Reset in the middle of a mix
    drive(16'sd9000, 16'sd9000, 16'sd9000, 16'sd9000, 8'd128, 8'd128, 8'd128, 8'd128, 1'b0);
    sample_clk = 1'b1;
    tick();
    sample_clk = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid/busy", 32'(busy), 32'd0);
    check("rst_mid/valid", 32'(valid), 32'd0);
    check("rst_mid/left", 32'(left), 32'd0);
    check("rst_mid/right", 32'(right), 32'd0);
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid) nvalid++;
    end
    check("rst_mid/no_valid", nvalid, 32'd0);

    // Strobe high through and after reset: no mix until a fresh edge
    rst = 1'b1;
    sample_clk = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (valid || busy) nvalid++;
    end
    check("strobe_hi/no_mix", nvalid, 32'd0);
    sample_clk = 1'b0;
    tick();
    mix("fresh_edge", 16'sd321, -16'sd654, 16'sd987, -16'sd111,
        8'd128, 8'd130, 8'd127, 8'd5, 1'b0, 1'b0, el, er);

    // Random mixes, biased toward full-scale samples now and then
    for (int i = 0; i < 40; i++) begin
      logic signed [15:0] ra, rb, rc, rd;
      ra = 16'($urandom); rb = 16'($urandom); rc = 16'($urandom); rd = 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ra = ra[15] ? -16'sd32768 : 16'sd32767;
        rd = rd[15] ? -16'sd32768 : 16'sd32767;
      end
      mix("rand", ra, rb, rc, rd, 8'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), ($urandom_range(0, 7) == 0), 1'b0, el, er);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
Four-channel audio mixer between the synth/APU channel outputs of the SoC core and the codec I2S output stage.
- Trigger: each rising edge of the codec sample strobe.
- Operation: snapshots channels A–D with per-channel gains, multiplies and accumulates on one time-shared multiplier, then saturates to 16-bit stereo.
- Outputs: left = A + C, right = B + D, each with a valid pulse and clip/overrun status.
- Placement: replaces the fixed-gain combinational sum/clamp that currently sits in front of the codec.

Parameters:
- GAIN_W, 8, width of each unsigned gain input; unity gain = 2^(GAIN_W-1) (128 at default).
- SAMPLE_W, 16, width of channel inputs and left/right outputs (signed two's complement).

Ports:
- clk_i  input  1  system clock (25 MHz domain, same as the sample strobe).
- rst_i  input  1  reset; synchronous, active-high.
- sample_clk_i  input  1  codec sample strobe; a rising edge requests one new mixed sample.
- channel_a_i  input  SAMPLE_W  signed channel A, mixed to left.
- channel_b_i  input  SAMPLE_W  signed channel B, mixed to right.
- channel_c_i  input  SAMPLE_W  signed channel C, mixed to left.
- channel_d_i  input  SAMPLE_W  signed channel D, mixed to right.
- gain_a_i  input  GAIN_W  unsigned gain for A.
- gain_b_i  input  GAIN_W  unsigned gain for B.
- gain_c_i  input  GAIN_W  unsigned gain for C.
- gain_d_i  input  GAIN_W  unsigned gain for D.
- mute_i  input  1  forces the next produced sample to zero.
- left_o  output  SAMPLE_W  signed mixed left sample; held between updates.
- right_o  output  SAMPLE_W  signed mixed right sample; held between updates.
- valid_o  output  1  one-cycle pulse when left_o/right_o update.
- clip_o  output  1  one-cycle pulse, coincident with valid_o, when either side saturated.
- overrun_o  output  1  one-cycle pulse when a strobe edge is dropped because the mixer is busy.
- busy_o  output  1  high while a mix is in progress (state != IDLE).

Behaviour:
- Single clock clk_i; rst_i is synchronous and active-high.
- Reset values:
  - left_o = right_o = 0.
  - valid_o = clip_o = overrun_o = busy_o = 0.
  - FSM = IDLE; accumulators = 0.
  - Strobe history register = 1, so a strobe already high out of reset is not treated as an edge.
- Edge detect: rise = sample_clk_i & ~prev; prev is registered every cycle.
- FSM states: IDLE -> MAC_A -> MAC_C -> MAC_B -> MAC_D -> SAT -> IDLE.
- IDLE, on rise in cycle N:
  - Capture all four channels, all four gains and mute_i into snapshot registers.
  - Clear acc_l and acc_r; go to MAC_A.
- MAC_A / MAC_C (N+1, N+2):
  - acc_l += ch * {1'b0, gain}.
  - Product is 16x9 signed = 25 bits; accumulators are 26 bits signed.
- MAC_B / MAC_D (N+3, N+4): acc_r += ch * {1'b0, gain}.
- SAT (N+5):
  - Arithmetic shift each accumulator right by GAIN_W-1 (floor toward -inf) to 19 bits.
  - Clamp to [-32768, 32767].
  - If the snapshot mute = 1, force both results to 0 and suppress clip.
  - Register the results into left_o/right_o at the end of this cycle.
- Output timing:
  - valid_o is high in cycle N+6 only; latency from edge to valid is 6 cycles.
  - clip_o is high in N+6 iff either clamp engaged.
- Busy and overrun:
  - busy_o is high in cycles N+1..N+5.
  - A rise while busy_o is high is dropped (no capture, no extra valid) and pulses overrun_o in that same cycle.
  - A rise in cycle N+6 (back in IDLE) is accepted normally.
- Input changes: channel or gain inputs changing after capture do not affect the sample in flight.
- Gain mapping: gain 0 gives exact 0; gain 128 is unity (bit-exact pass-through); gain 255 ≈ 1.99x.
- Reset mid-operation: aborts the mix; no valid_o; outputs return to reset values the cycle after rst_i is sampled high.

Test Plan:
- Unity mix: gains all 128; A=1000, C=2000, B=-500, D=-700; strobe rise in cycle N -> valid_o in N+6 only; left_o=3000, right_o=-1200, clip_o=0.
- Saturation:
  - A=C=32767, gains 255 -> left_o=32767, clip_o=1.
  - B=D=-32768, gains 255 -> right_o=-32768, clip_o=1.
  - Outputs hold until the next valid_o.
- Rounding: gain_a=64, A=1001, others 0 -> left_o=500; A=-1001 -> left_o=-501 (floor); gain 0 with any input -> 0.
- Mute and snapshot:
  - mute_i=1 at the edge with A=30000 -> left_o=right_o=0, clip_o=0.
  - Change channel_a_i at N+2 -> result still uses the value captured at N.
- Overrun: second strobe rise at N+3 -> overrun_o pulses at N+3; exactly one valid_o (N+6); a rise at N+6 yields valid_o at N+12.
- Reset:
  - rst_i asserted at N+3 -> no valid_o; left_o/right_o=0; busy_o=0 next cycle.
  - sample_clk_i held high through and after reset -> no mix until a fresh low->high transition.
